div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32 bits and register addresses at 5 bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, and no other clock or reset.
REQ-003 clk  input  1  rising-edge clock shared with the register file.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 funct3  input  3  operation select: 100 DIV, 101 DIVU, 110 REM, 111 REMU; 0xx SHALL be treated as DIVU.
REQ-007 rs1_data  input  32  dividend, taken from register-file read port 1.
REQ-008 rs2_data  input  32  divisor, taken from register-file read port 2.
REQ-009 rd_addr_in  input  5  destination register for the result.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse; the result is valid in that cycle.
REQ-012 result  output  32  quotient or remainder, driving the register-file write data.
REQ-013 rd_addr_out  output  5  latched destination, driving the register-file write address.
REQ-014 wren  output  1  register-file write enable; SHALL be identical to done.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, DIVIDE, FIXUP and DONE.
REQ-016 On a clock edge in IDLE with start=1, the block SHALL latch funct3, rd_addr_in and both operands.
- Signed ops: it SHALL also latch the operand magnitudes and their sign bits.
- Divisor zero or signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF): it SHALL go directly to DONE.
- Otherwise: it SHALL clear the iteration counter and go to DIVIDE.
REQ-017 DIVIDE SHALL perform one restoring shift-subtract iteration per clock, producing one quotient bit per iteration.
- The partial remainder SHALL be 33 bits wide so the trial subtraction never overflows.
REQ-018 After exactly 32 DIVIDE iterations, the block SHALL go to FIXUP.
- The 6-bit iteration counter SHALL never wrap.
REQ-019 FIXUP SHALL apply the sign corrections and go to DONE.
- Quotient: negated when the dividend and divisor signs differ (signed ops only).
- Remainder: negated when the dividend is negative (signed ops only).
REQ-020 DONE SHALL assert done=wren=1 for one cycle and return to IDLE on the next edge.
REQ-021 Normal latency: start sampled at edge E0; DIVIDE iterates on E1..E32; FIXUP is active after E32; done is high between E33 and E34.
REQ-022 Special-case latency: start sampled at E0; done is high between E0 and E1.
REQ-023 Divide-by-zero results SHALL be:
- DIV/DIVU quotient: 0xFFFFFFFF.
- REM/REMU remainder: the dividend, unchanged.
REQ-024 Signed-overflow results SHALL be:
- DIV quotient: 0x80000000.
- REM remainder: 0x00000000.
REQ-025 Normal results SHALL follow truncating division: the quotient rounds toward zero and the remainder satisfies dividend = q*divisor + r.
REQ-026 A start asserted while busy=1 SHALL be ignored, and the latched operands SHALL not change.
REQ-027 A start asserted in the same cycle that DONE returns to IDLE SHALL be ignored.
- The first accepted start is the one sampled in IDLE.
REQ-028 result and rd_addr_out SHALL hold their last values until the next DONE state.
- These values SHALL only be consumed when wren=1.
REQ-029 An rd_addr_in of 0 SHALL be processed normally.
- wren SHALL still pulse; suppressing the x0 write is the register file's job.

Reset
REQ-030 rst_n=0 SHALL, asynchronously and in any state, force:
- state to IDLE;
- busy, done and wren to 0;
- result, rd_addr_out, the counter and all internal registers to 0.
REQ-031 Reset asserted during DIVIDE or FIXUP SHALL abort the operation.
- No done or wren pulse SHALL occur for the aborted operation.
REQ-032 After reset deasserts, the first start sampled in IDLE SHALL be accepted normally.

Verification
REQ-033 DIVU: rs1=100, rs2=7, rd=5, start at E0 -> busy=1 from E0; done=wren=1 only between E33 and E34; result=14; rd_addr_out=5.
REQ-034 DIV and REM with rs1=0xFFFFFFF9 (-7), rs2=2:
- DIV -> result=0xFFFFFFFD (-3).
- REM -> result=0xFFFFFFFF (-1).
- Both -> done between E33 and E34.
REQ-035 Divide by zero with rs1=5, rs2=0:
- DIVU -> result=0xFFFFFFFF.
- REMU -> result=5.
- Both -> done between E0 and E1.
REQ-036 Signed overflow with rs1=0x80000000, rs2=0xFFFFFFFF:
- DIV -> result=0x80000000.
- REM -> result=0.
- Both -> done one cycle after start.
REQ-037 Start DIVU 100/7, then pulse start again with rs1=9, rs2=3 at E5 -> the second start is ignored; result=14 between E33 and E34.
REQ-038 Start DIVU, then drive rst_n=0 between E10 and E11 -> busy=0 immediately; result=0; no done pulse within the next 40 cycles.

Source files
------------

// File: rtl/div_unit.sv
// Iterative 32-bit integer divider (DIV/DIVU/REM/REMU) with a register-file write port.
// Restoring shift-subtract, one quotient bit per clock, signs corrected after the loop.
`timescale 1ns/1ps

module div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_addr_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_addr_out,
    output logic        wren
);

    // state  | meaning
    // IDLE   | waiting for start; operands latched on an accepted start
    // DIVIDE | one restoring iteration per clock, 32 in total
    // FIXUP  | sign correction of quotient/remainder, result registered
    // DONE   | done/wren pulse, result valid
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_FIXUP  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [2:0]  funct3_r;
    logic [4:0]  rd_addr_r;
    logic        sign1_r;
    logic        sign2_r;
    logic [31:0] quo_r;
    logic [31:0] dvs_r;
    logic [32:0] rem_r;
    logic [5:0]  cnt_r;

    logic        in_signed;
    logic        in_rem;
    logic        div_zero;
    logic        overflow;
    logic        special;
    logic [31:0] special_val;
    logic [31:0] abs1;
    logic [31:0] abs2;

    logic        op_signed;
    logic        op_rem;
    logic [33:0] diff;
    logic        borrow;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign in_signed = funct3[2] & ~funct3[0];
    assign in_rem    = funct3[2] & funct3[1];
    assign div_zero  = (rs2_data == 32'd0);
    assign overflow  = in_signed && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
    assign special   = div_zero | overflow;
    assign abs1      = (in_signed && rs1_data[31]) ? -rs1_data : rs1_data;
    assign abs2      = (in_signed && rs2_data[31]) ? -rs2_data : rs2_data;

    always_comb begin
        special_val = 32'd0;
        if (div_zero)
            special_val = in_rem ? rs1_data : 32'hFFFF_FFFF;
        else
            special_val = in_rem ? 32'd0 : 32'h8000_0000;
    end

    assign op_signed = funct3_r[2] & ~funct3_r[0];
    assign op_rem    = funct3_r[2] & funct3_r[1];

    // 34-bit trial subtraction: the top bit is a clean borrow even when the shifted remainder exceeds 32 bits
    assign diff   = {rem_r, quo_r[31]} - {2'b00, dvs_r};
    assign borrow = diff[33];

    assign quo_fix = (op_signed && (sign1_r ^ sign2_r)) ? -quo_r : quo_r;
    assign rem_fix = (op_signed && sign1_r) ? -rem_r[31:0] : rem_r[31:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nxt = special ? S_DONE : S_DIVIDE;
            end
            S_DIVIDE: begin
                if (cnt_r == 6'd31)
                    state_nxt = S_FIXUP;
            end
            S_FIXUP: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign wren = done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_r    <= 3'd0;
            rd_addr_r   <= 5'd0;
            sign1_r     <= 1'b0;
            sign2_r     <= 1'b0;
            quo_r       <= 32'd0;
            dvs_r       <= 32'd0;
            rem_r       <= 33'd0;
            cnt_r       <= 6'd0;
            result      <= 32'd0;
            rd_addr_out <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        funct3_r  <= funct3;
                        rd_addr_r <= rd_addr_in;
                        sign1_r   <= in_signed & rs1_data[31];
                        sign2_r   <= in_signed & rs2_data[31];
                        quo_r     <= abs1;
                        dvs_r     <= abs2;
                        rem_r     <= 33'd0;
                        cnt_r     <= 6'd0;
                        // special cases skip the loop, so their result is ready on the DONE entry edge
                        if (special) begin
                            result      <= special_val;
                            rd_addr_out <= rd_addr_in;
                        end
                    end
                end
                S_DIVIDE: begin
                    if (borrow) begin
                        rem_r <= {rem_r[31:0], quo_r[31]};
                        quo_r <= {quo_r[30:0], 1'b0};
                    end else begin
                        rem_r <= diff[32:0];
                        quo_r <= {quo_r[30:0], 1'b1};
                    end
                    cnt_r <= cnt_r + 6'd1;
                end
                S_FIXUP: begin
                    result      <= op_rem ? rem_fix : quo_fix;
                    rd_addr_out <= rd_addr_r;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model.
`timescale 1ns/1ps

module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_addr_out;
    logic        wren;

    int n_checks;
    int n_fail;

    div_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .funct3      (funct3),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rd_addr_in  (rd_addr_in),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .rd_addr_out (rd_addr_out),
        .wren        (wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        logic rem;
        sgn = f3[2] && !f3[0];
        rem = f3[2] && f3[1];
        if (b == 32'd0)
            return rem ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return rem ? 32'd0 : 32'h8000_0000;
            if (rem)
                return $signed(a) % $signed(b);
            return $signed(a) / $signed(b);
        end
        return rem ? (a % b) : (a / b);
    endfunction

    function automatic int model_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0)
            return 0;
        if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return 0;
        return 33;
    endfunction

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        int lat;
        @(negedge clk);
        funct3     = f3;
        rs1_data   = a;
        rs2_data   = b;
        rd_addr_in = rd;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        rs1_data = $urandom;
        rs2_data = $urandom;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(model_latency(f3, a, b)));
        chk({tag, "_result"}, result, model(f3, a, b));
        chk({tag, "_rd"}, 32'(rd_addr_out), 32'(rd));
        chk({tag, "_wren"}, 32'(wren), 32'd1);
        @(posedge clk);
        #1;
        chk({tag, "_done_low"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n_done;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        int sel;

        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        funct3     = 3'd0;
        rs1_data   = 32'd0;
        rs2_data   = 32'd0;
        rd_addr_in = 5'd0;

        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_wren", {31'd0, wren}, 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_rd", 32'(rd_addr_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd5);
        chk("divu_100_7_abs", result, 32'd14);
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd1);
        chk("div_m7_2_abs", result, 32'hFFFF_FFFD);
        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd2);
        chk("rem_m7_2_abs", result, 32'hFFFF_FFFF);
        run_op("divu_by0", 3'b101, 32'd5, 32'd0, 5'd3);
        run_op("remu_by0", 3'b111, 32'd5, 32'd0, 5'd4);
        chk("remu_by0_abs", result, 32'd5);
        run_op("div_by0", 3'b100, 32'hFFFF_FFF0, 32'd0, 5'd6);
        run_op("rem_by0", 3'b110, 32'hFFFF_FFF0, 32'd0, 5'd7);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
        chk("div_ovf_abs", result, 32'h8000_0000);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
        run_op("divu_ovf_pat", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
        run_op("remu_max", 3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 5'd11);
        run_op("f3_0xx", 3'b010, 32'hFFFF_FFF9, 32'd2, 5'd0);
        run_op("div_neg_neg", 3'b100, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd12);
        run_op("rem_pos_neg", 3'b110, 32'd100, 32'hFFFF_FFF9, 5'd13);

        for (int i = 0; i < 40; i++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 32'd0;
                1: b = $urandom_range(1, 20);
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = b >> $urandom_range(0, 31);
                4: a = $urandom_range(0, 100);
                5: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op("rand", f3, a, b, 5'($urandom));
        end

        // second start while busy is ignored; start during DONE is ignored too
        @(negedge clk);
        funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr_in = 5'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rs1_data = 32'd9; rs2_data = 32'd3; rd_addr_in = 5'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 5;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("busy_start_latency", 32'(lat), 32'd33);
        chk("busy_start_result", result, 32'd14);
        chk("busy_start_rd", 32'(rd_addr_out), 32'd5);
        rs1_data = 32'd50; rs2_data = 32'd5; rd_addr_in = 5'd3; start = 1'b1;
        @(posedge clk);
        #1;
        chk("done_start_ignored", 32'(busy), 32'd0);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("done_start_idle", {30'd0, done, busy}, 32'd0);
        chk("done_start_hold", result, 32'd14);

        // reset abort in the middle of DIVIDE
        @(negedge clk);
        funct3 = 3'b101; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr_in = 5'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_rd", 32'(rd_addr_out), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done || wren)
                n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);

        run_op("post_reset", 3'b111, 32'd100, 32'd7, 5'd31);
        chk("post_reset_abs", result, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
